// File: rtl/load_store_unit_pkg.sv
// Shared types, size encodings and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsuState_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [NUM_LANES-1:0] laneMask(input logic [1:0] ofs, input logic [1:0] size);
    case (size)
      SIZE_BYTE: laneMask = 4'b0001 << ofs;
      SIZE_HALF: laneMask = ofs[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: laneMask = 4'b1111;
      default:   laneMask = 4'b0000;
    endcase
  endfunction

  // Misaligned offset or reserved size; either one is reported as an error.
  function automatic logic badAlign(input logic [1:0] ofs, input logic [1:0] size);
    case (size)
      SIZE_BYTE: badAlign = 1'b0;
      SIZE_HALF: badAlign = ofs[0];
      SIZE_WORD: badAlign = |ofs;
      default:   badAlign = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_address;
  logic [31:0] mem_writeData;
  logic        mem_memWrite;
  logic        mem_memRead;
  logic [31:0] mem_readData;

  // The unit itself.
  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_readData,
    output busy, done, rdata, err, mem_address, mem_writeData, mem_memWrite, mem_memRead
  );

  // The surrounding CPU and memory.
  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_readData,
    input  busy, done, rdata, err, mem_address, mem_writeData, mem_memWrite, mem_memRead
  );
endinterface

// File: rtl/load_store_unit_lane_unit.sv
// Little-endian lane extract for loads and lane merge for stores.
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] wdata,
  output logic [31:0] loadVal,
  output logic [31:0] storeWord
);

  logic [NUM_LANES-1:0] mask;
  logic [31:0]          shifted;

  assign mask = laneMask(addr, size);

  // Right-align the addressed field, then zero- or sign-extend it.
  always_comb begin
    shifted = word;
    loadVal = word;
    case (size)
      SIZE_BYTE: begin
        shifted = word >> {addr, 3'b000};
        loadVal = {{24{signExt & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        shifted = word >> {addr[1], 4'b0000};
        loadVal = {{16{signExt & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted = word;
        loadVal = word;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    logic [LANE_W-1:0] src;

    // Store data is right-aligned, so a lane takes byte 0, byte k%2 or byte k of wdata.
    always_comb begin
      case (size)
        SIZE_BYTE: src = wdata[7:0];
        SIZE_HALF: src = wdata[LANE_W*(k%2) +: LANE_W];
        default:   src = wdata[LANE_W*k +: LANE_W];
      endcase
    end

    assign storeWord[LANE_W*k +: LANE_W] = mask[k] ? src : word[LANE_W*k +: LANE_W];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, sub-word stores done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 128
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) << 2;

  lsuState_e   state, nextState;
  logic [31:0] addrQ, wdataQ, wordQ, rdataQ;
  logic [1:0]  sizeQ;
  logic        signExtQ, weQ, errQ;
  logic        reqErr;
  logic [31:0] laneWord, loadVal, storeWord;

  assign reqErr = badAlign(bus.addr[1:0], bus.size) || (bus.addr >= MEM_BYTES);

  // In WRITE the merge works on the captured word; otherwise extract from live read data.
  assign laneWord = (state == WRITE) ? wordQ : bus.mem_readData;

  lsu_lane_unit uLane (
    .word      (laneWord),
    .addr      (addrQ[1:0]),
    .size      (sizeQ),
    .signExt   (signExtQ),
    .wdata     (wdataQ),
    .loadVal   (loadVal),
    .storeWord (storeWord)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (reqErr)                           nextState = DONE;
          else if (bus.we && bus.size == SIZE_WORD) nextState = WRITE;
          else                                  nextState = READ;
        end
      end
      READ:    nextState = weQ ? WRITE : DONE;
      WRITE:   nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // Request capture, read-word capture and load result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addrQ    <= '0;
      wdataQ   <= '0;
      sizeQ    <= '0;
      signExtQ <= 1'b0;
      weQ      <= 1'b0;
      errQ     <= 1'b0;
      wordQ    <= '0;
      rdataQ   <= '0;
    end else begin
      if (state == IDLE && bus.req) begin
        addrQ    <= bus.addr;
        wdataQ   <= bus.wdata;
        sizeQ    <= bus.size;
        signExtQ <= bus.sign_ext;
        weQ      <= bus.we;
        errQ     <= reqErr;
      end
      if (state == READ) begin
        wordQ <= bus.mem_readData;
        if (!weQ) rdataQ <= loadVal;
      end
    end
  end

  // Strobes depend on state only, so reset removes them at once.
  always_comb begin
    bus.busy          = (state != IDLE);
    bus.done          = (state == DONE);
    bus.err           = (state == DONE) && errQ;
    bus.rdata         = rdataQ;
    bus.mem_memRead   = (state == READ);
    bus.mem_memWrite  = (state == WRITE);
    bus.mem_writeData = (state == WRITE) ? storeWord : '0;
    bus.mem_address   = {addrQ[31:2], 2'b00};
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

  logic clock;
  logic reset_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(128)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        err;
    logic        chkData;
    logic [31:0] data;
    int          lat;
    int          reads;
    int          writes;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] memWords[128];
  logic [7:0]  refBytes[512];
  int          rdCnt, wrCnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign bus.mem_readData = memWords[bus.mem_address[8:2]];

  // Word memory seen by the DUT; commits on negedge.
  initial begin
    for (int i = 0; i < 128; i++) memWords[i] = $urandom;
    memWords[16] = 32'h8899AABB;
    forever begin
      @(negedge clock);
      if (bus.mem_memWrite) memWords[bus.mem_address[8:2]] = bus.mem_writeData;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(refBytes[a + i]) << (8 * i));
    if (n < 4 && sx && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  task automatic waitIdle();
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (!bus.busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    logic bad;
    waitIdle();
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx; bus.addr = a; bus.wdata = wd;
    bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'd512);
    e.acc = cyc; e.err = bad; e.chkData = 1'b0; e.data = '0;
    e.lat = 1; e.reads = 0; e.writes = 0;
    if (!bad && w) begin
      for (int i = 0; i < (1 << sz); i++) refBytes[a + i] = wd[8 * i +: 8];
      e.lat = (sz == 2'b10) ? 2 : 3;
      e.reads = (sz == 2'b10) ? 0 : 1;
      e.writes = 1;
    end else if (!bad) begin
      e.chkData = 1'b1;
      e.data = refLoad(a, sz, sx);
      e.lat = 2;
      e.reads = 1;
    end
    sb.push_back(e);
    @(posedge clock);
    #1 bus.req = 1'b0;
  endtask

  // Monitor: tallies memory strobes and scores every done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      rdCnt = 0; wrCnt = 0;
    end else begin
      if (bus.mem_memRead) rdCnt++;
      if (bus.mem_memWrite) wrCnt++;
      if (bus.mem_memRead && bus.mem_memWrite) check("rd_wr_both", 32'd1, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("err", 32'(bus.err), 32'(e.err));
          if (e.chkData) check("rdata", bus.rdata, e.data);
          check("latency", 32'(cyc - e.acc), 32'(e.lat));
          check("mem_reads", 32'(rdCnt), 32'(e.reads));
          check("mem_writes", 32'(wrCnt), 32'(e.writes));
        end
        rdCnt = 0; wrCnt = 0;
      end
    end
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a, old;
    int          k, n;
    vectors = 0; miscompares = 0; cyc = 0;
    rdCnt = 0; wrCnt = 0;
    reset_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = '0; bus.sign_ext = 1'b0; bus.addr = '0; bus.wdata = '0;
    #1;
    for (int i = 0; i < 128; i++)
      for (int b = 0; b < 4; b++) refBytes[4 * i + b] = memWords[i][8 * b +: 8];
    #2;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_memRead", 32'(bus.mem_memRead), 32'd0);
    check("rst_memWrite", 32'(bus.mem_memWrite), 32'd0);
    check("rst_writeData", bus.mem_writeData, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Directed cases around the word at 0x40.
    issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h42, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h43, 32'hDEAD005A);
    issue(1'b1, 2'b10, 1'b0, 32'h46, 32'h12345678);
    issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    waitIdle();
    check("word40_after_store", memWords[16], 32'h5A99AABB);

    // Random mix; mostly aligned, some misaligned, reserved or out of range.
    for (int t = 0; t < 300; t++) begin
      n = $urandom_range(0, 9);
      sz = (n < 3) ? 2'b00 : (n < 6) ? 2'b01 : (n < 9) ? 2'b10 : 2'b11;
      a = 32'($urandom_range(0, 'h21F));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
    end

    for (n = 0; n < 50 && sb.size() != 0; n++) @(negedge clock);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 128; i++) begin
      for (int b = 0; b < 4; b++) a[8 * b +: 8] = refBytes[4 * i + b];
      check($sformatf("mem[%0d]", i), memWords[i], a);
    end

    // Abort a word store in WRITE before its negedge commit.
    waitIdle();
    k = $urandom_range(0, 127);
    old = memWords[k];
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'(k) << 2; bus.wdata = ~old;
    @(posedge clock);
    #1 bus.req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("abort_memWrite", 32'(bus.mem_memWrite), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_err", 32'(bus.err), 32'd0);
    check("abort_rdata", bus.rdata, 32'd0);
    check("abort_writeData", bus.mem_writeData, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("abort_mem_unchanged", memWords[k], old);
    check("abort_idle", 32'(bus.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
